// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc
//   Set-associative instruction cache sitting between the fetch stage and
//   instruction memory. Serves one instruction per accepted request; misses
//   refill a whole line through a request/valid memory handshake. A global
//   flush invalidates every line and resets the round-robin victim pointers.
//
// Ports
//   inp_clk, inp_rst_n     clock, synchronous active-low reset
//   inp_req / out_ready    fetch request handshake (accepted when both high)
//   inp_address            fetch byte address
//   out_valid / out_hit    one-cycle response pulse, hit qualifier
//   out_instruction        fetched instruction
//   inp_flush              invalidate all lines (deferred until idle)
//   out_mem_req            refill request, held until inp_mem_valid
//   out_mem_address        line-aligned refill byte address
//   inp_mem_valid          inp_lineData valid this cycle
//   inp_lineData           refill line, word k at [INSTR_W*k +: INSTR_W]
//
// Optional feature (macro ICACHE_STATS_EN)
//   out_hit_count / out_miss_count: 16-bit saturating response counters,
//   cleared only by reset.
// ---------------------------------------------------------------------------
module icache_assoc #(
  parameter int ADDR_W         = 16,
  parameter int INSTR_W        = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 8,
  parameter int WAYS           = 2
) (
  input  logic                              inp_clk,
  input  logic                              inp_rst_n,
  input  logic                              inp_req,
  input  logic [ADDR_W-1:0]                 inp_address,
  output logic                              out_ready,
  output logic                              out_valid,
  output logic                              out_hit,
  output logic [INSTR_W-1:0]                out_instruction,
  input  logic                              inp_flush,
  output logic                              out_mem_req,
  output logic [ADDR_W-1:0]                 out_mem_address,
  input  logic                              inp_mem_valid,
  input  logic [INSTR_W*WORDS_PER_LINE-1:0] inp_lineData
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]                       out_hit_count,
  output logic [15:0]                       out_miss_count
`endif
);

  localparam int LINE_W  = INSTR_W * WORDS_PER_LINE;
  localparam int BYTE_W  = $clog2(INSTR_W / 8);
  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int LINE_SH = BYTE_W + OFF_W;
  localparam int TAG_SH  = LINE_SH + $clog2(SETS);
  localparam int TAG_W   = ADDR_W - TAG_SH;
  localparam int IDX_W   = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                flushPending_q, flushPending_d;
  logic                outValid_q, outValid_d;
  logic                outHit_q, outHit_d;
  logic [INSTR_W-1:0]  outInstr_q, outInstr_d;
  logic                memReq_q, memReq_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;

  logic                valid_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [LINE_W-1:0]   data_q  [SETS][WAYS];
  logic [WAY_W-1:0]    rr_q    [SETS];

  logic [IDX_W-1:0]    idx;
  logic [OFF_W-1:0]    off;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [WAY_W-1:0]    hitWay;
  logic [WAY_W-1:0]    victim;
  logic                freeFound;
  logic                doFlush;
  logic                refillWe;

  // Fields of the latched request address; the mask keeps SETS == 1 legal.
  assign idx = IDX_W'((addr_q >> LINE_SH) & ADDR_W'(SETS - 1));
  assign off = OFF_W'(addr_q >> BYTE_W);
  assign tag = TAG_W'(addr_q >> TAG_SH);

  // Tag match across the indexed set, and victim choice: the lowest invalid
  // way wins, otherwise the set's round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hitWay    = '0;
    freeFound = 1'b0;
    victim    = rr_q[idx];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
      if (!freeFound && !valid_q[idx][w]) begin
        freeFound = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  // Next-state and response logic. A flush is only ever executed from IDLE,
  // so it can never collide with a refill write in the same cycle.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    flushPending_d = flushPending_q | inp_flush;
    outValid_d     = 1'b0;
    outHit_d       = outHit_q;
    outInstr_d     = outInstr_q;
    memReq_d       = memReq_q;
    memAddr_d      = memAddr_q;
    out_ready      = 1'b0;
    doFlush        = 1'b0;
    refillWe       = 1'b0;
    case (state_q)
      IDLE: begin
        out_ready = !inp_flush && !flushPending_q;
        if (flushPending_q || inp_flush) begin
          doFlush        = 1'b1;
          flushPending_d = 1'b0;
        end else if (inp_req) begin
          addr_d  = inp_address;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          outValid_d = 1'b1;
          outHit_d   = 1'b1;
          outInstr_d = data_q[idx][hitWay][INSTR_W*off +: INSTR_W];
          state_d    = IDLE;
        end else begin
          memReq_d  = 1'b1;
          memAddr_d = (addr_q >> LINE_SH) << LINE_SH;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        if (inp_mem_valid) begin
          refillWe   = 1'b1;
          memReq_d   = 1'b0;
          outValid_d = 1'b1;
          outHit_d   = 1'b0;
          outInstr_d = inp_lineData[INSTR_W*off +: INSTR_W];
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, registered outputs and line metadata.
  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      flushPending_q <= 1'b0;
      outValid_q     <= 1'b0;
      outHit_q       <= 1'b0;
      outInstr_q     <= '0;
      memReq_q       <= 1'b0;
      memAddr_q      <= '0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
        end
      end
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      flushPending_q <= flushPending_d;
      outValid_q     <= outValid_d;
      outHit_q       <= outHit_d;
      outInstr_q     <= outInstr_d;
      memReq_q       <= memReq_d;
      memAddr_q      <= memAddr_d;
      if (doFlush) begin
        for (int s = 0; s < SETS; s++) begin
          rr_q[s] <= '0;
          for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
        end
      end else if (refillWe) begin
        valid_q[idx][victim] <= 1'b1;
        tag_q[idx][victim]   <= tag;
        rr_q[idx]            <= (WAYS > 1) ? rr_q[idx] + 1'b1 : '0;
      end
    end
  end

  // Line data needs no reset: it is never read while its valid bit is clear.
  always_ff @(posedge inp_clk) begin
    if (refillWe) data_q[idx][victim] <= inp_lineData;
  end

  assign out_valid       = outValid_q;
  assign out_hit         = outHit_q;
  assign out_instruction = outInstr_q;
  assign out_mem_req     = memReq_q;
  assign out_mem_address = memAddr_q;

`ifdef ICACHE_STATS_EN
  logic [15:0] hitCount_q, missCount_q;

  // Counters follow the response pulse and stick at all-ones.
  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else if (outValid_q) begin
      if (outHit_q) begin
        if (hitCount_q != 16'hFFFF) hitCount_q <= hitCount_q + 16'd1;
      end else begin
        if (missCount_q != 16'hFFFF) missCount_q <= missCount_q + 16'd1;
      end
    end
  end

  assign out_hit_count  = hitCount_q;
  assign out_miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc
//   Directed self-checking bench for icache_assoc with default parameters
//   (tag = [15:6], index = [5:3], offset = [2:1]). Memory answers one cycle
//   after it sees out_mem_req. Optional counters are checked when
//   ICACHE_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_icache_assoc;

  logic        inp_clk;
  logic        inp_rst_n;
  logic        inp_req;
  logic [15:0] inp_address;
  logic        out_ready;
  logic        out_valid;
  logic        out_hit;
  logic [15:0] out_instruction;
  logic        inp_flush;
  logic        out_mem_req;
  logic [15:0] out_mem_address;
  logic        inp_mem_valid;
  logic [63:0] inp_lineData;
`ifdef ICACHE_STATS_EN
  logic [15:0] out_hit_count;
  logic [15:0] out_miss_count;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  localparam logic [63:0] LINE_A = 64'hFFFF_FFF0_FF00_F000;
  localparam logic [63:0] LINE_B = 64'h1111_1110_1100_1000;
  localparam logic [63:0] LINE_C = 64'h4444_4443_4442_4441;
  localparam logic [63:0] LINE_D = 64'h8888_8887_8886_8885;
  localparam logic [63:0] LINE_E = 64'h2222_2221_2220_222F;

  icache_assoc dut (
    .inp_clk         (inp_clk),
    .inp_rst_n       (inp_rst_n),
    .inp_req         (inp_req),
    .inp_address     (inp_address),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_hit         (out_hit),
    .out_instruction (out_instruction),
    .inp_flush       (inp_flush),
    .out_mem_req     (out_mem_req),
    .out_mem_address (out_mem_address),
    .inp_mem_valid   (inp_mem_valid),
    .inp_lineData    (inp_lineData)
`ifdef ICACHE_STATS_EN
    ,
    .out_hit_count   (out_hit_count),
    .out_miss_count  (out_miss_count)
`endif
  );

  initial inp_clk = 1'b0;
  always #5 inp_clk = ~inp_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  // One fetch: waits for out_ready, issues the request, answers a refill one
  // cycle after out_mem_req is seen, and reports the response. Latency is the
  // number of falling edges after the accepting edge until out_valid is seen.
  task automatic applyStimulus(input logic [15:0] addr, input logic [63:0] line,
                               output logic gotHit, output logic [15:0] gotInstr,
                               output logic sawMemReq, output logic [15:0] memAddr,
                               output int latency);
    bit accepted = 0;
    bit drove    = 0;
    bit done     = 0;
    gotHit    = 1'bx;
    gotInstr  = 16'hxxxx;
    sawMemReq = 1'b0;
    memAddr   = 16'hxxxx;
    latency   = -1;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge inp_clk);
      if (out_ready) begin
        inp_req     = 1'b1;
        inp_address = addr;
        @(posedge inp_clk);
        accepted = 1;
        #1 inp_req = 1'b0;
      end
    end
    if (!accepted) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL acceptTimeout addr %h: got no out_ready, expected out_ready within 20 cycles", addr);
      return;
    end
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge inp_clk);
      inp_mem_valid = 1'b0;
      if (out_valid) begin
        gotHit   = out_hit;
        gotInstr = out_instruction;
        latency  = i;
        done     = 1;
      end else if (out_mem_req && !drove) begin
        sawMemReq     = 1'b1;
        memAddr       = out_mem_address;
        inp_mem_valid = 1'b1;
        inp_lineData  = line;
        drove         = 1;
      end
    end
    if (!done) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL responseTimeout addr %h: got no out_valid, expected out_valid within 20 cycles", addr);
    end
  endtask

  task automatic test_reset();
    inp_rst_n = 1'b0; inp_req = 1'b0; inp_address = '0; inp_flush = 1'b0;
    inp_mem_valid = 1'b0; inp_lineData = '0;
    repeat (3) @(posedge inp_clk);
    #1 inp_rst_n = 1'b1;
    @(negedge inp_clk);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetValid: got %b expected 0", out_valid); end
    nCompared++; if (out_hit !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetHit: got %b expected 0", out_hit); end
    nCompared++; if (out_mem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetMemReq: got %b expected 0", out_mem_req); end
    nCompared++; if (out_instruction !== 16'h0000) begin nMismatched++; $display("[TB] FAIL resetInstr: got %h expected 0000", out_instruction); end
    nCompared++; if (out_mem_address !== 16'h0000) begin nMismatched++; $display("[TB] FAIL resetMemAddr: got %h expected 0000", out_mem_address); end
    nCompared++; if (out_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL resetReady: got %b expected 1", out_ready); end
`ifdef ICACHE_STATS_EN
    nCompared++; if (out_hit_count !== 16'd0) begin nMismatched++; $display("[TB] FAIL resetHitCount: got %0d expected 0", out_hit_count); end
    nCompared++; if (out_miss_count !== 16'd0) begin nMismatched++; $display("[TB] FAIL resetMissCount: got %0d expected 0", out_miss_count); end
`endif
  endtask

  task automatic test_cold_miss();
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    applyStimulus(16'h0000, LINE_A, h, ins, mr, ma, lat);
    nCompared++; if (mr !== 1'b1) begin nMismatched++; $display("[TB] FAIL coldMemReq: got %b expected 1", mr); end
    nCompared++; if (ma !== 16'h0000) begin nMismatched++; $display("[TB] FAIL coldMemAddr: got %h expected 0000", ma); end
    nCompared++; if (h !== 1'b0) begin nMismatched++; $display("[TB] FAIL coldHit: got %b expected 0", h); end
    nCompared++; if (ins !== 16'hF000) begin nMismatched++; $display("[TB] FAIL coldInstr: got %h expected F000", ins); end
    nCompared++; if (lat !== 3) begin nMismatched++; $display("[TB] FAIL coldLatency: got %0d expected 3", lat); end
    @(negedge inp_clk);
    nCompared++; if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL coldPulse: got %b expected 0", out_valid); end
  endtask

  task automatic test_line_hits();
    logic [15:0] addrs [3] = '{16'h0002, 16'h0004, 16'h0006};
    logic [15:0] words [3] = '{16'hFF00, 16'hFFF0, 16'hFFFF};
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(addrs[k], 64'h0, h, ins, mr, ma, lat);
      nCompared++; if (h !== 1'b1) begin nMismatched++; $display("[TB] FAIL lineHit%0d: got %b expected 1", k, h); end
      nCompared++; if (ins !== words[k]) begin nMismatched++; $display("[TB] FAIL lineInstr%0d: got %h expected %h", k, ins, words[k]); end
      nCompared++; if (mr !== 1'b0) begin nMismatched++; $display("[TB] FAIL lineMemReq%0d: got %b expected 0", k, mr); end
      nCompared++; if (lat !== 2) begin nMismatched++; $display("[TB] FAIL lineLatency%0d: got %0d expected 2", k, lat); end
    end
  endtask

  task automatic test_second_set();
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    applyStimulus(16'h0008, LINE_B, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h} !== 2'b10) begin nMismatched++; $display("[TB] FAIL set1Miss: got memReq,hit %b%b expected 10", mr, h); end
    nCompared++; if (ma !== 16'h0008) begin nMismatched++; $display("[TB] FAIL set1MemAddr: got %h expected 0008", ma); end
    nCompared++; if (ins !== 16'h1000) begin nMismatched++; $display("[TB] FAIL set1Instr: got %h expected 1000", ins); end
    applyStimulus(16'h000A, 64'h0, h, ins, mr, ma, lat);
    nCompared++; if ({h, ins} !== {1'b1, 16'h1100}) begin nMismatched++; $display("[TB] FAIL set1Hit: got %b %h expected 1 1100", h, ins); end
    applyStimulus(16'h0000, 64'h0, h, ins, mr, ma, lat);
    nCompared++; if ({h, ins} !== {1'b1, 16'hF000}) begin nMismatched++; $display("[TB] FAIL set0StillHit: got %b %h expected 1 F000", h, ins); end
  endtask

  task automatic test_replacement();
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    // Set 0: way0 holds 0x0000, pointer at 1. 0x0040 takes free way1.
    applyStimulus(16'h0040, LINE_C, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'h4441}) begin nMismatched++; $display("[TB] FAIL fill40: got %b%b %h expected 10 4441", mr, h, ins); end
    nCompared++; if (ma !== 16'h0040) begin nMismatched++; $display("[TB] FAIL fill40Addr: got %h expected 0040", ma); end
    // Set full, pointer wrapped to 0: 0x0080 evicts 0x0000 from way0.
    applyStimulus(16'h0080, LINE_D, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'h8885}) begin nMismatched++; $display("[TB] FAIL fill80: got %b%b %h expected 10 8885", mr, h, ins); end
    applyStimulus(16'h0040, 64'h0, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b01, 16'h4441}) begin nMismatched++; $display("[TB] FAIL hit40: got %b%b %h expected 01 4441", mr, h, ins); end
    applyStimulus(16'h0000, LINE_A, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'hF000}) begin nMismatched++; $display("[TB] FAIL evicted00: got %b%b %h expected 10 F000", mr, h, ins); end
  endtask

  task automatic test_flush_refill();
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    bit seen = 0;
    @(negedge inp_clk);
    inp_req = 1'b1; inp_address = 16'h0010;
    @(posedge inp_clk);
    #1 inp_req = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge inp_clk);
      if (out_mem_req) seen = 1;
    end
    nCompared++; if (!seen) begin nMismatched++; $display("[TB] FAIL flushMemReq: got 0 expected out_mem_req within 10 cycles"); end
    inp_flush = 1'b1;
    @(negedge inp_clk);
    inp_flush = 1'b0; inp_mem_valid = 1'b1; inp_lineData = LINE_E;
    @(negedge inp_clk);
    inp_mem_valid = 1'b0;
    nCompared++; if ({out_valid, out_hit} !== 2'b10) begin nMismatched++; $display("[TB] FAIL flushDeliver: got valid,hit %b%b expected 10", out_valid, out_hit); end
    nCompared++; if (out_instruction !== 16'h222F) begin nMismatched++; $display("[TB] FAIL flushInstr: got %h expected 222F", out_instruction); end
    nCompared++; if (out_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL flushReadyLow: got %b expected 0", out_ready); end
    @(negedge inp_clk);
    nCompared++; if (out_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flushReadyBack: got %b expected 1", out_ready); end
    applyStimulus(16'h0000, LINE_A, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'hF000}) begin nMismatched++; $display("[TB] FAIL reMiss00: got %b%b %h expected 10 F000", mr, h, ins); end
    applyStimulus(16'h0008, LINE_B, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'h1000}) begin nMismatched++; $display("[TB] FAIL reMiss08: got %b%b %h expected 10 1000", mr, h, ins); end
  endtask

  task automatic test_reset_refill();
    logic [15:0] addrs [3] = '{16'h0002, 16'h0004, 16'h0006};
    logic h; logic [15:0] ins; logic mr; logic [15:0] ma; int lat;
    bit seen = 0;
    @(negedge inp_clk);
    inp_req = 1'b1; inp_address = 16'h0020;
    @(posedge inp_clk);
    #1 inp_req = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge inp_clk);
      if (out_mem_req) seen = 1;
    end
    nCompared++; if (!seen) begin nMismatched++; $display("[TB] FAIL rstMemReqSeen: got 0 expected out_mem_req within 10 cycles"); end
    inp_rst_n = 1'b0;
    @(negedge inp_clk);
    nCompared++; if (out_mem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstMemReqDrop: got %b expected 0", out_mem_req); end
    nCompared++; if (out_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstReady: got %b expected 1", out_ready); end
    inp_rst_n = 1'b1;
    applyStimulus(16'h0000, LINE_A, h, ins, mr, ma, lat);
    nCompared++; if ({mr, h, ins} !== {2'b10, 16'hF000}) begin nMismatched++; $display("[TB] FAIL rstMiss00: got %b%b %h expected 10 F000", mr, h, ins); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(addrs[k], 64'h0, h, ins, mr, ma, lat);
      nCompared++; if (h !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstHit%0d: got %b expected 1", k, h); end
    end
    @(negedge inp_clk);
`ifdef ICACHE_STATS_EN
    nCompared++; if (out_hit_count !== 16'd3) begin nMismatched++; $display("[TB] FAIL statHits: got %0d expected 3", out_hit_count); end
    nCompared++; if (out_miss_count !== 16'd1) begin nMismatched++; $display("[TB] FAIL statMisses: got %0d expected 1", out_miss_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_second_set();
    test_replacement();
    test_flush_refill();
    test_reset_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
